ram_init_restore_ctrl: RTL and testbench



---
 rtl/ram_init_restore_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ram_init_restore_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_init_restore_ctrl.sv
// Initialisation / fast-restore initiator for a multi-port RAM: zero or sequential fill after
// reset, and a read-back-then-write copy on request. Optional stats: RAM_INIT_CTRL_STATS_EN.
module ram_init_restore_ctrl #(
  parameter int DEPTH        = 16,
  parameter int INDEX        = 4,
  parameter int WIDTH        = 8,
  parameter int NUM_WR_PORTS = 4,
  parameter int RESET_VAL    = 0,
  parameter int SEQ_START    = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            restoreReq_i,
  output logic [NUM_WR_PORTS*INDEX-1:0]   rdAddr_o,
  input  logic [NUM_WR_PORTS*WIDTH-1:0]   rdData_i,
  output logic [NUM_WR_PORTS*INDEX-1:0]   addrWr_o,
  output logic [NUM_WR_PORTS*WIDTH-1:0]   dataWr_o,
  output logic [NUM_WR_PORTS-1:0]         wrEn_o,
  output logic                            ownPorts_o,
  output logic                            ramReady_o
`ifdef RAM_INIT_CTRL_STATS_EN
  ,
  output logic [15:0]                     busyCycles_o,
  output logic [7:0]                      restoreCount_o
`endif
);

  localparam int AW = INDEX + 1;
  localparam logic [INDEX:0] DEPTH_W = AW'(DEPTH);
  localparam logic [INDEX:0] STEP_W  = AW'(NUM_WR_PORTS);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RESTORE, S_DRAIN} state_t;

  state_t                          r_state, w_nextState;
  logic [INDEX:0]                  r_base, w_nextBase;
  logic                            r_pending, w_nextPending;
  logic [NUM_WR_PORTS*INDEX-1:0]   r_addrWr, w_addrWr;
  logic [NUM_WR_PORTS*WIDTH-1:0]   r_dataWr, w_dataWr;
  logic [NUM_WR_PORTS-1:0]         r_wrEn, w_wrEn;
  logic                            r_ready, r_own;
  logic [INDEX:0]                  w_laneIdx [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0]         w_laneVld;
  logic                            w_lastGroup, w_initDone;

  function automatic logic [WIDTH-1:0] fill_val(input logic [INDEX:0] idx);
    if (RESET_VAL == 0) return '0;
    return WIDTH'(SEQ_START) + WIDTH'(idx);
  endfunction

  // One extra address bit so a group running past DEPTH is caught even when DEPTH = 2^INDEX.
  always_comb begin
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      w_laneIdx[i] = r_base + AW'(i);
      w_laneVld[i] = (w_laneIdx[i] < DEPTH_W);
    end
  end

  assign w_lastGroup = ({1'b0, r_base} + {1'b0, STEP_W}) >= {1'b0, DEPTH_W};
  assign w_initDone  = (r_base >= DEPTH_W);

  always_comb begin
    rdAddr_o = '0;
    if (r_state == S_RESTORE) begin
      for (int i = 0; i < NUM_WR_PORTS; i++)
        if (w_laneVld[i]) rdAddr_o[i*INDEX +: INDEX] = w_laneIdx[i][INDEX-1:0];
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextBase    = r_base;
    w_nextPending = r_pending | restoreReq_i;
    w_wrEn        = '0;
    w_addrWr      = '0;
    w_dataWr      = '0;
    case (r_state)
      S_INIT: begin
        // Base parks at DEPTH after the last group; the following edge hands over to IDLE.
        if (w_initDone) begin
          w_nextState = S_IDLE;
          w_nextBase  = '0;
        end else begin
          for (int i = 0; i < NUM_WR_PORTS; i++) begin
            w_wrEn[i]                   = w_laneVld[i];
            w_addrWr[i*INDEX +: INDEX]  = w_laneIdx[i][INDEX-1:0];
            w_dataWr[i*WIDTH +: WIDTH]  = fill_val(w_laneIdx[i]);
          end
          w_nextBase = w_lastGroup ? DEPTH_W : r_base + STEP_W;
        end
      end
      S_IDLE: begin
        w_nextPending = 1'b0;
        if (restoreReq_i || r_pending) begin
          w_nextState = S_RESTORE;
          w_nextBase  = '0;
        end
      end
      S_RESTORE: begin
        for (int i = 0; i < NUM_WR_PORTS; i++) begin
          w_wrEn[i]                   = w_laneVld[i];
          w_addrWr[i*INDEX +: INDEX]  = w_laneIdx[i][INDEX-1:0];
          w_dataWr[i*WIDTH +: WIDTH]  = rdData_i[i*WIDTH +: WIDTH];
        end
        if (w_lastGroup) begin
          w_nextState = S_DRAIN;
          w_nextBase  = '0;
        end else begin
          w_nextBase = r_base + STEP_W;
        end
      end
      S_DRAIN: w_nextState = S_IDLE;
      default: w_nextState = S_INIT;
    endcase
  end

  // Write lanes are registered: the read captured this cycle is written back next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_base    <= '0;
      r_pending <= 1'b0;
      r_wrEn    <= '0;
      r_addrWr  <= '0;
      r_dataWr  <= '0;
      r_ready   <= 1'b0;
      r_own     <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_base    <= w_nextBase;
      r_pending <= w_nextPending;
      r_wrEn    <= w_wrEn;
      r_addrWr  <= w_addrWr;
      r_dataWr  <= w_dataWr;
      r_ready   <= (w_nextState == S_IDLE);
      r_own     <= (w_nextState != S_IDLE);
    end
  end

  assign wrEn_o     = r_wrEn;
  assign addrWr_o   = r_addrWr;
  assign dataWr_o   = r_dataWr;
  assign ramReady_o = r_ready;
  assign ownPorts_o = r_own;

`ifdef RAM_INIT_CTRL_STATS_EN
  logic [15:0] r_busyCycles;
  logic [7:0]  r_restoreCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busyCycles   <= '0;
      r_restoreCount <= '0;
    end else begin
      if ((w_nextState != S_IDLE) && (r_busyCycles != 16'hFFFF))
        r_busyCycles <= r_busyCycles + 16'd1;
      if (r_state == S_DRAIN)
        r_restoreCount <= r_restoreCount + 8'd1;
    end
  end

  assign busyCycles_o   = r_busyCycles;
  assign restoreCount_o = r_restoreCount;
`endif

endmodule

// File: tb/tb_ram_init_restore_ctrl.sv
// Bench for ram_init_restore_ctrl: two instances (16-entry zero fill, 10-entry sequential fill)
// each driving a behavioural RAM; write traffic of the first is checked against a queue.
module tb_ram_init_restore_ctrl;
  localparam int N = 4;
  localparam int I = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, req_a = 1'b0, req_b = 1'b0;
  logic [N*I-1:0] rdAddr_a, addrWr_a, rdAddr_b, addrWr_b;
  logic [N*W-1:0] rdData_a, dataWr_a, rdData_b, dataWr_b;
  logic [N-1:0]   wrEn_a, wrEn_b;
  logic           own_a, ready_a, own_b, ready_b;
`ifdef RAM_INIT_CTRL_STATS_EN
  logic [15:0] busy_a, busy_b;
  logic [7:0]  rc_a, rc_b;
`endif
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_data = '0;
  logic [7:0] mem_a [16] = '{default: 8'h5A};
  logic [7:0] mem_b [16] = '{default: 8'h5A};
  logic [7:0] exp_a [16];

  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t sbq[$];
  wr_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;

  ram_init_restore_ctrl #(.DEPTH(16), .INDEX(4), .WIDTH(8), .NUM_WR_PORTS(4),
                          .RESET_VAL(0), .SEQ_START(0)) u_dut_a (
    .clk(clk), .reset(rst_a), .restoreReq_i(req_a), .rdAddr_o(rdAddr_a), .rdData_i(rdData_a),
    .addrWr_o(addrWr_a), .dataWr_o(dataWr_a), .wrEn_o(wrEn_a), .ownPorts_o(own_a),
    .ramReady_o(ready_a)
`ifdef RAM_INIT_CTRL_STATS_EN
    , .busyCycles_o(busy_a), .restoreCount_o(rc_a)
`endif
  );

  ram_init_restore_ctrl #(.DEPTH(10), .INDEX(4), .WIDTH(8), .NUM_WR_PORTS(4),
                          .RESET_VAL(1), .SEQ_START(248)) u_dut_b (
    .clk(clk), .reset(rst_b), .restoreReq_i(req_b), .rdAddr_o(rdAddr_b), .rdData_i(rdData_b),
    .addrWr_o(addrWr_b), .dataWr_o(dataWr_b), .wrEn_o(wrEn_b), .ownPorts_o(own_b),
    .ramReady_o(ready_b)
`ifdef RAM_INIT_CTRL_STATS_EN
    , .busyCycles_o(busy_b), .restoreCount_o(rc_b)
`endif
  );

  // RAM A: controller lanes plus a host port muxed in only while the controller lets go.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (wrEn_a[i]) mem_a[addrWr_a[i*I +: I]] <= dataWr_a[i*W +: W];
    if (host_we && !own_a) mem_a[host_addr] <= host_data;
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (wrEn_b[i]) mem_b[addrWr_b[i*I +: I]] <= dataWr_b[i*W +: W];
  end

  always_comb begin
    rdData_a = '0;
    rdData_b = '0;
    for (int i = 0; i < N; i++) begin
      rdData_a[i*W +: W] = mem_a[rdAddr_a[i*I +: I]];
      rdData_b[i*W +: W] = mem_b[rdAddr_b[i*I +: I]];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (wrEn_a[i] === 1'b1) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL sb_write lane %0d: got addr=%0d data=%h, required no write",
                   i, addrWr_a[i*I +: I], dataWr_a[i*W +: W]);
        end else begin
          mon_e = sbq.pop_front();
          if (addrWr_a[i*I +: I] !== mon_e.a || dataWr_a[i*W +: W] !== mon_e.d) begin
            n_err++;
            $display("FAIL sb_write lane %0d: got addr=%0d data=%h, required addr=%0d data=%h",
                     i, addrWr_a[i*I +: I], dataWr_a[i*W +: W], mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  task automatic test_reset();
    int e;
    int w;
    rst_a = 1'b1;
    @(negedge clk);
    n_vec++; if (wrEn_a !== '0) begin n_err++; $display("FAIL rst_wrEn: got %b required 0", wrEn_a); end
    n_vec++; if (own_a !== 1'b1) begin n_err++; $display("FAIL rst_own: got %b required 1", own_a); end
    n_vec++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b required 0", ready_a); end
    n_vec++; if (rdAddr_a !== '0) begin n_err++; $display("FAIL rst_rdAddr: got %h required 0", rdAddr_a); end
    n_vec++; if (addrWr_a !== '0 || dataWr_a !== '0) begin
      n_err++; $display("FAIL rst_wrbus: got addr=%h data=%h required 0", addrWr_a, dataWr_a);
    end
    for (int k = 0; k < 16; k++) sbq.push_back({4'(k), 8'h00});
    rst_a = 1'b0;
    e = 0; w = 0;
    do begin
      @(posedge clk); @(negedge clk);
      e++;
      if (wrEn_a != '0) w++;
    end while (ready_a !== 1'b1 && e < 20);
    n_vec++; if (e != 5) begin n_err++; $display("FAIL init_ready_edge: got %0d required 5", e); end
    n_vec++; if (w != 4) begin n_err++; $display("FAIL init_wr_cycles: got %0d required 4", w); end
    n_vec++; if (sbq.size() != 0) begin n_err++; $display("FAIL init_sb_left: got %0d required 0", sbq.size()); end
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (mem_a[k] !== 8'h00) begin n_err++; $display("FAIL init_mem[%0d]: got %h required 00", k, mem_a[k]); end
    end
  endtask

  task automatic test_restore();
    int  own_cyc;
    bit  prev5;
    bit  saw_follow;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      host_we = 1'b1; host_addr = 4'(k);
      host_data = (k == 5) ? 8'hA5 : 8'(k * 13 + 7);
      exp_a[k] = host_data;
    end
    @(negedge clk);
    host_we = 1'b0;
    for (int k = 0; k < 16; k++) sbq.push_back({4'(k), exp_a[k]});
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    n_vec++; if (ready_a !== 1'b0 || own_a !== 1'b1) begin
      n_err++; $display("FAIL restore_start: got ready=%b own=%b required ready=0 own=1", ready_a, own_a);
    end
    own_cyc = 0; prev5 = 1'b0; saw_follow = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (t > 0) @(negedge clk);
      if (prev5) begin
        saw_follow = 1'b1;
        n_vec++;
        if (addrWr_a[7:4] !== 4'd5 || dataWr_a[15:8] !== 8'hA5 || wrEn_a[1] !== 1'b1) begin
          n_err++;
          $display("FAIL restore_follow: got addr=%0d data=%h en=%b required addr=5 data=a5 en=1",
                   addrWr_a[7:4], dataWr_a[15:8], wrEn_a[1]);
        end
      end
      prev5 = (own_a === 1'b1) && (rdAddr_a[7:4] === 4'd5);
      if (ready_a === 1'b1) break;
      if (own_a === 1'b1) own_cyc++;
    end
    n_vec++; if (own_cyc != 5) begin n_err++; $display("FAIL restore_own_cycles: got %0d required 5", own_cyc); end
    n_vec++; if (saw_follow !== 1'b1) begin n_err++; $display("FAIL restore_rdaddr5: got %b required 1", saw_follow); end
    n_vec++; if (sbq.size() != 0) begin n_err++; $display("FAIL restore_sb_left: got %0d required 0", sbq.size()); end
    n_vec++; if (mem_a[5] !== 8'hA5) begin n_err++; $display("FAIL restore_mem5: got %h required a5", mem_a[5]); end
  endtask

  task automatic test_pending_during_init();
    int  rises;
    int  run1;
    bit  prev;
    rst_a = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 32; k++) sbq.push_back({4'(k % 16), 8'h00});
    rst_a = 1'b0;
    rises = 0; run1 = 0; prev = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); @(negedge clk);
      req_a = (t == 0);
      if (ready_a === 1'b1 && !prev) rises++;
      if (rises == 1 && ready_a === 1'b1) run1++;
      prev = (ready_a === 1'b1);
    end
    n_vec++; if (rises != 2) begin n_err++; $display("FAIL pend_ready_rises: got %0d required 2", rises); end
    n_vec++; if (run1 != 1) begin n_err++; $display("FAIL pend_idle_gap: got %0d required 1", run1); end
    n_vec++; if (sbq.size() != 0) begin n_err++; $display("FAIL pend_sb_left: got %0d required 0", sbq.size()); end
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL pend_final_ready: got %b required 1", ready_a); end
  endtask

  task automatic test_reset_mid_restore();
    int e;
    int nr;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      host_we = 1'b1; host_addr = 4'(k); host_data = 8'(8'h30 + k);
      exp_a[k] = host_data;
    end
    @(negedge clk);
    host_we = 1'b0;
    for (int k = 0; k < 8; k++) sbq.push_back({4'(k), exp_a[k]});
    for (int k = 0; k < 16; k++) sbq.push_back({4'(k), 8'h00});
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    #1 rst_a = 1'b1;
    #1;
    n_vec++; if (wrEn_a !== '0) begin n_err++; $display("FAIL abort_wrEn: got %b required 0", wrEn_a); end
    n_vec++; if (ready_a !== 1'b0 || own_a !== 1'b1) begin
      n_err++; $display("FAIL abort_flags: got ready=%b own=%b required ready=0 own=1", ready_a, own_a);
    end
    n_vec++; if (rdAddr_a !== '0) begin n_err++; $display("FAIL abort_rdAddr: got %h required 0", rdAddr_a); end
    @(negedge clk);
    rst_a = 1'b0;
    e = 0;
    do begin
      @(posedge clk); @(negedge clk);
      e++;
    end while (ready_a !== 1'b1 && e < 20);
    n_vec++; if (e != 5) begin n_err++; $display("FAIL abort_reinit_edge: got %0d required 5", e); end
    nr = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (ready_a !== 1'b1) nr++;
    end
    n_vec++; if (nr != 0) begin n_err++; $display("FAIL abort_pending_dropped: got %0d busy cycles required 0", nr); end
    n_vec++; if (sbq.size() != 0) begin n_err++; $display("FAIL abort_sb_left: got %0d required 0", sbq.size()); end
  endtask

  task automatic test_stats();
    int e;
    rst_a = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 32; k++) sbq.push_back({4'(k % 16), 8'h00});
    rst_a = 1'b0;
    e = 0;
    do begin
      @(posedge clk); @(negedge clk);
      e++;
    end while (ready_a !== 1'b1 && e < 20);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    e = 0;
    do begin
      @(negedge clk);
      e++;
    end while (ready_a !== 1'b1 && e < 20);
    n_vec++; if (e != 5) begin n_err++; $display("FAIL stats_restore_len: got %0d required 5", e); end
    n_vec++; if (sbq.size() != 0) begin n_err++; $display("FAIL stats_sb_left: got %0d required 0", sbq.size()); end
`ifdef RAM_INIT_CTRL_STATS_EN
    n_vec++; if (busy_a !== 16'd9) begin n_err++; $display("FAIL stats_busy: got %0d required 9", busy_a); end
    n_vec++; if (rc_a !== 8'd1) begin n_err++; $display("FAIL stats_restores: got %0d required 1", rc_a); end
`endif
  endtask

  task automatic test_seq_fill();
    int         e;
    int         w;
    logic [3:0] last_en;
    logic [3:0] la0, la1;
    logic [7:0] ld0, ld1;
    rst_b = 1'b1;
    @(negedge clk);
    n_vec++; if (wrEn_b !== '0 || ready_b !== 1'b0 || own_b !== 1'b1) begin
      n_err++; $display("FAIL seq_rst: got en=%b ready=%b own=%b required en=0 ready=0 own=1",
                        wrEn_b, ready_b, own_b);
    end
    rst_b = 1'b0;
    e = 0; w = 0; last_en = '0; la0 = '0; la1 = '0; ld0 = '0; ld1 = '0;
    do begin
      @(posedge clk); @(negedge clk);
      e++;
      if (wrEn_b != '0) begin
        w++; last_en = wrEn_b;
        la0 = addrWr_b[3:0]; la1 = addrWr_b[7:4];
        ld0 = dataWr_b[7:0]; ld1 = dataWr_b[15:8];
      end
    end while (ready_b !== 1'b1 && e < 20);
    n_vec++; if (e != 4) begin n_err++; $display("FAIL seq_ready_edge: got %0d required 4", e); end
    n_vec++; if (w != 3) begin n_err++; $display("FAIL seq_wr_cycles: got %0d required 3", w); end
    n_vec++; if (last_en !== 4'b0011) begin n_err++; $display("FAIL seq_last_en: got %b required 0011", last_en); end
    n_vec++; if (la0 !== 4'd8 || la1 !== 4'd9) begin
      n_err++; $display("FAIL seq_last_addr: got %0d,%0d required 8,9", la0, la1);
    end
    n_vec++; if (ld0 !== 8'h00 || ld1 !== 8'h01) begin
      n_err++; $display("FAIL seq_last_data: got %h,%h required 00,01", ld0, ld1);
    end
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (mem_b[k] !== 8'(248 + k)) begin
        n_err++; $display("FAIL seq_mem[%0d]: got %h required %h", k, mem_b[k], 8'(248 + k));
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_restore();
    test_pending_during_init();
    test_reset_mid_restore();
    test_stats();
    test_seq_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
